// File: rtl/alu_result_seq_if.sv
// Handshake and SR bus bundle for the ALU result sequencer.
// The master drives the request and data bus; the slave (sequencer) drives strobes and status.
interface alu_result_seq_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] dbus;
  logic       isum_n;
  logic       isub_n;
  logic       imul_n;
  logic       idiv_n;
  logic       ishl_n;
  logic       ishr_n;
  logic       esr_n;
  logic       ready;
  logic       done;
  logic       err;
  logic [7:0] result;

  modport master (
    output start, op, dbus,
    input  isum_n, isub_n, imul_n, idiv_n, ishl_n, ishr_n,
    input  esr_n, ready, done, err, result
  );

  modport slave (
    input  start, op, dbus,
    output isum_n, isub_n, imul_n, idiv_n, ishl_n, ishr_n,
    output esr_n, ready, done, err, result
  );
endinterface

// File: rtl/alu_result_seq.sv
// ALU result sequencer: strobes the selected SR, enables it onto DBUS, captures RESULT, pulses DONE.
// Optional macro ALU_RESULT_SEQ_SHIFT_EN makes SHL/SHR legal; otherwise they raise ERR.
module alu_result_seq #(
  parameter int unsigned MULDIV_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_result_seq_if.slave  bus
);

`ifdef ALU_RESULT_SEQ_SHIFT_EN
  localparam int STB_W = 6;
`else
  localparam int STB_W = 4;
`endif
  localparam logic [7:0] WAIT_LOAD = 8'(MULDIV_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_STROBE, S_READ, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q, op_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [STB_W-1:0] stb_n, stb_nxt;
  logic             esr_n, esr_nxt;
  logic             ready, ready_nxt;
  logic             done, done_nxt;
  logic             err, err_nxt;
  logic [7:0]       result, result_nxt;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef ALU_RESULT_SEQ_SHIFT_EN
    return op <= 3'd5;
`else
    return op <= 3'd3;
`endif
  endfunction

  // Strobe bit i belongs to opcode i, so a legal opcode clears exactly one bit.
  function automatic logic [STB_W-1:0] strobe_for(input logic [2:0] op);
    logic [STB_W-1:0] s;
    for (int i = 0; i < STB_W; i++) s[i] = (op != i[2:0]);
    return s;
  endfunction

  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    cnt_nxt    = cnt;
    stb_nxt    = '1;
    esr_nxt    = 1'b1;
    ready_nxt  = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    result_nxt = result;
    case (state)
      S_IDLE: begin
        ready_nxt = 1'b1;
        if (bus.start) begin
          if (op_legal(bus.op)) begin
            op_nxt    = bus.op;
            ready_nxt = 1'b0;
            if (bus.op == 3'd2 || bus.op == 3'd3) begin
              state_nxt = S_WAIT;
              cnt_nxt   = WAIT_LOAD;
            end else begin
              state_nxt = S_STROBE;
              stb_nxt   = strobe_for(bus.op);
            end
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 8'd1) begin
          state_nxt = S_STROBE;
          cnt_nxt   = 8'd0;
          stb_nxt   = strobe_for(op_q);
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      S_STROBE: begin
        state_nxt = S_READ;
        esr_nxt   = 1'b0;
      end
      S_READ: begin
        state_nxt  = S_DONE;
        done_nxt   = 1'b1;
        result_nxt = bus.dbus;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // Outputs are registered from the same next-state decode, so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 8'd0;
      stb_n  <= '1;
      esr_n  <= 1'b1;
      ready  <= 1'b1;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= 8'h00;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      stb_n  <= stb_nxt;
      esr_n  <= esr_nxt;
      ready  <= ready_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      result <= result_nxt;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_nxt;
  end

  assign bus.isum_n = stb_n[0];
  assign bus.isub_n = stb_n[1];
  assign bus.imul_n = stb_n[2];
  assign bus.idiv_n = stb_n[3];
`ifdef ALU_RESULT_SEQ_SHIFT_EN
  assign bus.ishl_n = stb_n[4];
  assign bus.ishr_n = stb_n[5];
`else
  assign bus.ishl_n = 1'b1;
  assign bus.ishr_n = 1'b1;
`endif
  assign bus.esr_n  = esr_n;
  assign bus.ready  = ready;
  assign bus.done   = done;
  assign bus.err    = err;
  assign bus.result = result;

endmodule

// File: tb/tb_alu_result_seq.sv
// Scoreboard bench for alu_result_seq: directed operations with per-cycle strobe/status checks.
module tb_alu_result_seq;
  localparam int MD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_result_seq_if bus();

  alu_result_seq #(.MULDIV_CYCLES(MD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] res;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [7:0] last_res;
  int         checks = 0;
  int         errors = 0;

  // {isum,isub,imul,idiv,ishl,ishr,esr,ready,done,err}
  function automatic logic [9:0] status();
    return {bus.isum_n, bus.isub_n, bus.imul_n, bus.idiv_n, bus.ishl_n, bus.ishr_n,
            bus.esr_n, bus.ready, bus.done, bus.err};
  endfunction

  localparam logic [9:0] IDLE_ST = {6'h3F, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] data, input bit hold);
    int w;
    int s_cyc;
    logic [5:0] s;
    logic [9:0] exp;
    w = (op == 3'd2 || op == 3'd3) ? MD : 0;
    s_cyc = 1 + w;
    bus.start = 1'b1;
    bus.op    = op;
    bus.dbus  = data;
    q.push_back(exp_t'{1'b0, data});
    last_res = data;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    for (int c = 1; c <= w + 4; c++) begin
      s = 6'h3F;
      if (c == s_cyc) s[5 - int'(op)] = 1'b0;
      exp = {s, (c == s_cyc + 1) ? 1'b0 : 1'b1, (c == s_cyc + 3), (c == s_cyc + 2), 1'b0};
      check($sformatf("op%0d_cyc%0d", op, c), 32'(status()), 32'(exp));
      if (c < w + 4) begin
        @(posedge clk); #1;
      end
    end
    check($sformatf("op%0d_result", op), 32'(bus.result), 32'(data));
  endtask

  task automatic run_err(input logic [2:0] op);
    bus.start = 1'b1;
    bus.op    = op;
    q.push_back(exp_t'{1'b1, last_res});
    @(posedge clk); #1;
    bus.start = 1'b0;
    check($sformatf("err%0d_pulse", op), 32'(status()), 32'({6'h3F, 1'b1, 1'b1, 1'b0, 1'b1}));
    @(posedge clk); #1;
    check($sformatf("err%0d_clear", op), 32'(status()), 32'(IDLE_ST));
    check($sformatf("err%0d_result", op), 32'(bus.result), 32'(last_res));
  endtask

  // Monitor: every DONE or ERR pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst && (bus.done || bus.err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: done=%b err=%b result=%h with nothing expected",
                 bus.done, bus.err, bus.result);
      end else begin
        e = q.pop_front();
        if ({bus.done, bus.err} !== (e.is_err ? 2'b01 : 2'b10) || bus.result !== e.res) begin
          errors++;
          $display("FAIL event: done=%b err=%b result=%h expected err_event=%b result=%h",
                   bus.done, bus.err, bus.result, e.is_err, e.res);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.dbus  = 8'h00;
    last_res  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_status", 32'(status()), 32'(IDLE_ST));
    check("reset_result", 32'(bus.result), 32'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 8'h3C, 1'b0);
    run_op(3'd2, 8'hA5, 1'b0);
    run_op(3'd1, 8'h5A, 1'b1);
    run_op(3'd1, 8'hC3, 1'b0);
    run_op(3'd3, 8'h7E, 1'b0);
    run_op(3'd2, 8'h33, 1'b1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("idle_after_hold", 32'(status()), 32'(IDLE_ST));
    run_err(3'd7);
    run_err(3'd6);
`ifdef ALU_RESULT_SEQ_SHIFT_EN
    run_op(3'd4, 8'h81, 1'b0);
    run_op(3'd5, 8'h18, 1'b0);
`else
    run_err(3'd4);
    run_err(3'd5);
`endif

    // Abort a DIV in its strobe cycle.
    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.dbus  = 8'h99;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (MD) @(posedge clk);
    #1;
    check("div_strobe_before_reset", 32'(status()), 32'({6'b111011, 1'b1, 1'b0, 1'b0, 1'b0}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_res = 8'h00;
    check("abort_status", 32'(status()), 32'(IDLE_ST));
    check("abort_result", 32'(bus.result), 32'h00);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("abort_quiet%0d", i), 32'(status()), 32'(IDLE_ST));
    end

    // Reset wins over a simultaneous START.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.op    = 3'd0;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_prio0", 32'(status()), 32'(IDLE_ST));
    @(posedge clk); #1;
    check("rst_prio1", 32'(status()), 32'(IDLE_ST));

    run_op(3'd0, 8'h42, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_result_seq.md
ALU_RESULT_SEQ -- requirements
Module: alu_result_seq

Interface
REQ-001 Parameter MULDIV_CYCLES, default 8, SHALL set the wait cycles before the SR load strobe for MUL/DIV; legal range 1..255.
REQ-002 CLK  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 START  input  1  SHALL be the operation request, accepted only when READY=1.
REQ-005 OP  input  3  SHALL be the opcode, sampled on acceptance: 0 SUM, 1 SUB, 2 MUL, 3 DIV, 4 SHL, 5 SHR, 6-7 illegal.
REQ-006 DBUS  input  8  SHALL be the data bus, carrying the SR value while ESRn=0.
REQ-007 ISUMn, ISUBn, IMULn, IDIVn, ISHLn, ISHRn  output  1 each  SHALL be the active-low SR load strobes.
REQ-008 ESRn  output  1  SHALL be the active-low SR bus-output enable.
REQ-009 READY  output  1  SHALL be high only in IDLE.
REQ-010 DONE  output  1  SHALL be a one-cycle completion pulse.
REQ-011 ERR  output  1  SHALL be a one-cycle illegal-opcode pulse.
REQ-012 RESULT  output  8  SHALL hold the last value captured from DBUS.

Function
REQ-013 States SHALL be IDLE, WAIT, STROBE, READ, DONE; all outputs SHALL be registered.
REQ-014 IDLE: START=1 with a legal OP SHALL go to WAIT for MUL/DIV, otherwise to STROBE.
REQ-015 WAIT SHALL last exactly MULDIV_CYCLES cycles, counted by an 8-bit down-counter, then go to STROBE.
REQ-016 STROBE SHALL drive exactly one strobe low, the one matching the latched opcode, for exactly one cycle, then go to READ.
REQ-017 At most one of the six strobes SHALL be low in any cycle; ESRn SHALL never be low in the same cycle as any strobe.
REQ-018 READ SHALL drive ESRn low for exactly one cycle; RESULT SHALL load DBUS at the edge ending READ; the state SHALL then go to DONE.
REQ-019 DONE SHALL assert DONE for one cycle with RESULT already valid, then return to IDLE.
REQ-020 RESULT SHALL hold its value until the next READ capture.
REQ-021 Latency (accept edge = k): SUM/SUB/SHL/SHR: strobe in cycle k+1, ESRn in k+2, DONE in k+3, READY in k+4. MUL/DIV: every step is MULDIV_CYCLES cycles later.
REQ-022 In IDLE, START with an illegal OP SHALL pulse ERR in the next cycle, stay in IDLE, and leave READY high.
REQ-023 START outside IDLE SHALL be ignored and not queued.
REQ-024 In IDLE, WAIT and DONE, all strobes and ESRn SHALL be high.

Reset
REQ-025 RST=1 at an edge SHALL force IDLE, all strobes and ESRn high, READY=1, DONE=0, ERR=0, RESULT=8'h00, WAIT counter=0.
REQ-026 Reset mid-operation (WAIT/STROBE/READ) SHALL abort with no further strobe or ESRn pulse; RST SHALL take priority over START in the same cycle.

Configuration
REQ-027 Macro ALU_RESULT_SEQ_SHIFT_EN defined: SHL/SHR SHALL be legal and drive ISHLn/ISHRn per REQ-016.
REQ-028 Macro absent: OP 4/5 SHALL be illegal per REQ-022, and ISHLn/ISHRn SHALL be constantly high.

Verification
REQ-029 Reset, then START with OP=0 at edge k, DBUS=8'h3C -> ISUMn=0 in k+1 only, ESRn=0 in k+2 only, DONE=1 in k+3 with RESULT=8'h3C, READY=1 in k+4.
REQ-030 MULDIV_CYCLES=8, OP=2, DBUS=8'hA5 -> IMULn=0 in k+9, ESRn=0 in k+10, DONE in k+11, RESULT=8'hA5.
REQ-031 OP=7 at edge k -> ERR=1 in k+1 only, no strobe, READY stays 1, RESULT unchanged.
REQ-032 RST=1 during the cycle with IDIVn=0 -> from the next cycle all strobes and ESRn high, READY=1, RESULT=8'h00, no DONE.
REQ-033 START with OP=1 held high through the whole operation -> a single ISUBn pulse, then a second accept only after READY returns.
REQ-034 OP=5 -> with ALU_RESULT_SEQ_SHIFT_EN, ISHRn=0 in k+1; without it, ERR=1 in k+1 and ISHRn stays high.
